sysid_check_ctrl: RTL and testbench
===================================

Name: sysid_check_ctrl

Overview:
- Avalon-MM read master that sequences two reads of the system-ID slave: word 0 (ID) and word 1 (build timestamp).
- Compares both words against compile-time expected values.
- Reports pass/fail, timeout and captured words to the board-test status logic.
- Runs automatically once after reset, then again on each start pulse.

Parameters:
- EXPECTED_ID, 32'h0000_0000, expected word at address 0.
- EXPECTED_TS, 32'h511B_0352 (1360724818), expected word at address 1.
- CHECK_TS, 1, 1 = timestamp mismatch fails the check; 0 = timestamp captured only.
- USE_RDV, 1, 1 = data returns on avm_readdatavalid; 0 = data sampled in the accept cycle (read high, waitrequest low).
- TIMEOUT_CYCLES, 1024, per-read cycle limit, counted from read assertion to data return.
- MAX_RETRY, 2, retries of the whole sequence after a timeout before reporting failure.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request to rerun the check; ignored unless busy=0.
- avm_address  out  1  word address to the sysid slave.
- avm_read  out  1  read request.
- avm_waitrequest  in  1  slave stall.
- avm_readdata  in  32  read data.
- avm_readdatavalid  in  1  read data valid; unused when USE_RDV=0.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle pulse at sequence end.
- id_ok  out  1  captured ID equals EXPECTED_ID.
- ts_ok  out  1  captured timestamp equals EXPECTED_TS (forced 1 if CHECK_TS=0).
- pass  out  1  id_ok & ts_ok & ~timeout_err.
- timeout_err  out  1  retries exhausted without complete data.
- id_value  out  32  last captured ID.
- ts_value  out  32  last captured timestamp.

Behaviour:
- Reset values: avm_read=0, avm_address=0, busy=0, done=0, id_ok=0, ts_ok=0, pass=0, timeout_err=0, id_value=0, ts_value=0, retry count=0, timeout counter=0. FSM enters AUTO.
- AUTO: one cycle after reset release, moves to RD_ID. An internal auto-run flag clears after this first entry.
- IDLE: on start=1, clears status outputs (id_ok, ts_ok, pass, timeout_err) and retry count, then moves to RD_ID. Captured values hold until overwritten.
- RD_ID: avm_read=1, avm_address=0, busy=1.
  - avm_address and avm_read stay stable while avm_waitrequest=1.
  - On accept (waitrequest=0): with USE_RDV=0, captures readdata into id_value and goes to RD_TS; with USE_RDV=1, drops avm_read next cycle and goes to WT_ID.
- WT_ID: waits for avm_readdatavalid, captures id_value, goes to RD_TS.
- RD_TS / WT_TS: identical to RD_ID / WT_ID with avm_address=1; capture goes to ts_value, then the FSM moves to CMP.
- Only one read is outstanding at a time. A readdatavalid seen in any state other than WT_ID/WT_TS is ignored.
- CMP (1 cycle): registers id_ok, ts_ok and pass; asserts done for exactly one cycle; goes to IDLE with busy=0. Total latency with a zero-wait slave and USE_RDV=0 is 4 cycles from leaving IDLE to done.
- Timeout: counter clears on entry to each RD_* state and increments every cycle in RD_*/WT_*.
  - When the count reaches TIMEOUT_CYCLES-1 without data, avm_read drops.
  - If retries < MAX_RETRY: retry count increments, FSM goes to RD_ID after a 1-cycle gap.
  - Otherwise: timeout_err=1, pass=0, id_ok=0, ts_ok=0, done pulses, FSM goes to IDLE.
  - A late readdatavalid after a timeout is discarded.
- Simultaneous events: if data arrives in the same cycle the timeout terminal count is reached, the data wins. start while busy=1 is ignored.
- Comparisons are full 32-bit equality; no masking.
- Reset asserted mid-sequence clears all state immediately, and the auto-run repeats after release.

Test Plan:
- Zero-wait slave, USE_RDV=0, ID=0, TS=0x511B0352 -> after reset release, done pulses once; pass=1, id_value=0, ts_value=0x511B0352; exactly 2 read accepts, address 0 then 1.
- ID slave returns 0x0000_0001 -> id_ok=0, pass=0, ts_ok=1, done pulses once.
- Timestamp mismatch with CHECK_TS=0 -> ts_ok=1, pass=1, ts_value holds the returned value.
- Waitrequest held 5 cycles per read, USE_RDV=1, readdatavalid 3 cycles after accept -> avm_address/avm_read stable during stall; pass=1; no second read issued while one is outstanding.
- Slave never returns data, TIMEOUT_CYCLES=16, MAX_RETRY=2 -> 3 attempts of address-0 reads, timeout_err=1, pass=0 at about 3×16 cycles plus gaps; start then reruns with a good slave -> pass=1, timeout_err=0.
- start pulsed during busy and reset_n asserted mid-WT_TS -> start ignored; on reset all outputs return to 0 and the auto-run restarts.

Source files
------------

// File: rtl/sysid_check_ctrl.sv
// sysid_check_ctrl: Avalon-MM read master that fetches the sysid ID word and
// build timestamp, checks both against expected values and reports status.
module sysid_check_ctrl #(
    parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_TS    = 32'h511B_0352,
    parameter bit          CHECK_TS       = 1'b1,
    parameter bit          USE_RDV        = 1'b1,
    parameter int          TIMEOUT_CYCLES = 1024,
    parameter int          MAX_RETRY      = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        pass,
    output logic        timeout_err,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_AUTO,
        S_IDLE,
        S_RD_ID,
        S_WT_ID,
        S_RD_TS,
        S_WT_TS,
        S_CMP,
        S_GAP
    } state_t;

    state_t        state_q, state_d;
    logic          auto_q, auto_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          done_q, done_d;
    logic          id_ok_q, id_ok_d;
    logic          ts_ok_q, ts_ok_d;
    logic          pass_q, pass_d;
    logic          terr_q, terr_d;
    logic [31:0]   id_value_q, id_value_d;
    logic [31:0]   ts_value_q, ts_value_d;

    logic in_rd;
    logic in_wt;
    logic accept;
    logic rvalid;
    logic tmo_hit;
    logic fail;

    always_comb begin
        state_d    = state_q;
        auto_d     = auto_q;
        retry_d    = retry_q;
        tmo_d      = tmo_q;
        done_d     = 1'b0;
        id_ok_d    = id_ok_q;
        ts_ok_d    = ts_ok_q;
        pass_d     = pass_q;
        terr_d     = terr_q;
        id_value_d = id_value_q;
        ts_value_d = ts_value_q;
        fail       = 1'b0;

        in_rd   = (state_q == S_RD_ID) || (state_q == S_RD_TS);
        in_wt   = (state_q == S_WT_ID) || (state_q == S_WT_TS);
        accept  = in_rd && !avm_waitrequest;
        rvalid  = in_wt && avm_readdatavalid;
        tmo_hit = (in_rd || in_wt) && (tmo_q >= TMO_LAST);

        if (in_rd || in_wt) begin
            tmo_d = tmo_q + TW'(1);
        end

        unique case (state_q)
            S_AUTO: begin
                if (auto_q) begin
                    auto_d  = 1'b0;
                    state_d = S_RD_ID;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                if (start) begin
                    id_ok_d = 1'b0;
                    ts_ok_d = 1'b0;
                    pass_d  = 1'b0;
                    terr_d  = 1'b0;
                    retry_d = '0;
                    state_d = S_RD_ID;
                end
            end
            S_RD_ID: begin
                if (accept) begin
                    if (USE_RDV) begin
                        state_d = S_WT_ID;
                    end else begin
                        id_value_d = avm_readdata;
                        state_d    = S_RD_TS;
                    end
                end else if (tmo_hit) begin
                    fail = 1'b1;
                end
            end
            S_WT_ID: begin
                if (rvalid) begin
                    id_value_d = avm_readdata;
                    state_d    = S_RD_TS;
                end else if (tmo_hit) begin
                    fail = 1'b1;
                end
            end
            S_RD_TS: begin
                if (accept) begin
                    if (USE_RDV) begin
                        state_d = S_WT_TS;
                    end else begin
                        ts_value_d = avm_readdata;
                        state_d    = S_CMP;
                    end
                end else if (tmo_hit) begin
                    fail = 1'b1;
                end
            end
            S_WT_TS: begin
                if (rvalid) begin
                    ts_value_d = avm_readdata;
                    state_d    = S_CMP;
                end else if (tmo_hit) begin
                    fail = 1'b1;
                end
            end
            S_CMP: begin
                id_ok_d = (id_value_q == EXPECTED_ID);
                ts_ok_d = !CHECK_TS || (ts_value_q == EXPECTED_TS);
                pass_d  = id_ok_d && ts_ok_d;
                terr_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            S_GAP: begin
                state_d = S_RD_ID;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A timeout restarts the whole sequence from the ID read
        if (fail) begin
            if (retry_q < RETRY_MAX) begin
                retry_d = retry_q + RW'(1);
                state_d = S_GAP;
            end else begin
                terr_d  = 1'b1;
                pass_d  = 1'b0;
                id_ok_d = 1'b0;
                ts_ok_d = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
        end

        if ((state_d != state_q) &&
            ((state_d == S_RD_ID) || (state_d == S_RD_TS))) begin
            tmo_d = '0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_AUTO;
            auto_q     <= 1'b1;
            retry_q    <= '0;
            tmo_q      <= '0;
            done_q     <= 1'b0;
            id_ok_q    <= 1'b0;
            ts_ok_q    <= 1'b0;
            pass_q     <= 1'b0;
            terr_q     <= 1'b0;
            id_value_q <= '0;
            ts_value_q <= '0;
        end else begin
            state_q    <= state_d;
            auto_q     <= auto_d;
            retry_q    <= retry_d;
            tmo_q      <= tmo_d;
            done_q     <= done_d;
            id_ok_q    <= id_ok_d;
            ts_ok_q    <= ts_ok_d;
            pass_q     <= pass_d;
            terr_q     <= terr_d;
            id_value_q <= id_value_d;
            ts_value_q <= ts_value_d;
        end
    end

    assign avm_read    = (state_q == S_RD_ID) || (state_q == S_RD_TS);
    assign avm_address = (state_q == S_RD_TS);
    assign busy        = (state_q != S_AUTO) && (state_q != S_IDLE);
    assign done        = done_q;
    assign id_ok       = id_ok_q;
    assign ts_ok       = ts_ok_q;
    assign pass        = pass_q;
    assign timeout_err = terr_q;
    assign id_value    = id_value_q;
    assign ts_value    = ts_value_q;

endmodule

// File: tb/tb_sysid_check_ctrl.sv
// tb_sysid_check_ctrl: two controller instances (readdatavalid and accept-
// cycle variants) against behavioural sysid slaves with a result scoreboard.
module tb_sysid_check_ctrl;

  localparam logic [31:0] TS_GOOD = 32'h511B_0352;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic        a_start = 1'b0, a_wr = 1'b1, a_rdv = 1'b0;
  logic [31:0] a_rdata = '0;
  logic        a_addr, a_read, a_busy, a_done;
  logic        a_idok, a_tsok, a_pass, a_tmo;
  logic [31:0] a_idv, a_tsv;

  logic        b_start = 1'b0, b_wr = 1'b0, b_rdv = 1'b0;
  logic [31:0] b_rdata = '0;
  logic        b_addr, b_read, b_busy, b_done;
  logic        b_idok, b_tsok, b_pass, b_tmo;
  logic [31:0] b_idv, b_tsv;

  sysid_check_ctrl #(
    .CHECK_TS(1'b1), .USE_RDV(1'b1),
    .TIMEOUT_CYCLES(16), .MAX_RETRY(2)
  ) u_a (
    .clock(clk), .reset_n(rst_n), .start(a_start),
    .avm_address(a_addr), .avm_read(a_read),
    .avm_waitrequest(a_wr), .avm_readdata(a_rdata),
    .avm_readdatavalid(a_rdv),
    .busy(a_busy), .done(a_done), .id_ok(a_idok),
    .ts_ok(a_tsok), .pass(a_pass), .timeout_err(a_tmo),
    .id_value(a_idv), .ts_value(a_tsv)
  );

  sysid_check_ctrl #(
    .CHECK_TS(1'b0), .USE_RDV(1'b0)
  ) u_b (
    .clock(clk), .reset_n(rst_n), .start(b_start),
    .avm_address(b_addr), .avm_read(b_read),
    .avm_waitrequest(b_wr), .avm_readdata(b_rdata),
    .avm_readdatavalid(b_rdv),
    .busy(b_busy), .done(b_done), .id_ok(b_idok),
    .ts_ok(b_tsok), .pass(b_pass), .timeout_err(b_tmo),
    .id_value(b_idv), .ts_value(b_tsv)
  );

  logic [31:0] a_id = 32'h0, a_ts = TS_GOOD;
  logic [31:0] b_id = 32'h0, b_ts = TS_GOOD;
  int a_wait = 5, a_dly = 3;
  bit a_dead = 1'b0;
  int a_pend = 0, a_stall = 0, a_ovl = 0, a_stv = 0, a_att = 0;
  bit a_padr = 1'b0, a_prd = 1'b0, a_paddr = 1'b0, a_pwr = 1'b1;
  bit a_log[$];
  bit b_log[$];
  int a_dcnt = 0, b_dcnt = 0;
  logic [67:0] qa[$];
  logic [67:0] qb[$];

  // slave A: programmable stall, readdatavalid delay, or no response
  initial begin
    forever begin
      @(negedge clk);
      a_rdata = $urandom;
      a_rdv = 1'b0;
      if (!rst_n) begin
        a_pend = 0; a_stall = 0; a_wr = 1'b1;
        a_prd = 1'b0; a_pwr = 1'b1;
      end else begin
        if (a_pend > 0) begin
          a_pend--;
          if (a_pend == 0) begin
            a_rdv = 1'b1;
            a_rdata = a_padr ? a_ts : a_id;
          end
        end
        if (a_read && a_pend > 0) a_ovl++;
        if (a_prd && a_pwr && !a_dead &&
            (!a_read || a_addr != a_paddr)) a_stv++;
        if (a_read && !a_prd && !a_addr) a_att++;
        a_prd = a_read;
        a_paddr = a_addr;
        if (a_read && !a_dead) begin
          if (a_stall < a_wait) begin
            a_wr = 1'b1; a_stall++;
          end else begin
            a_wr = 1'b0; a_stall = 0;
            a_pend = a_dly; a_padr = a_addr;
            a_log.push_back(a_addr);
          end
        end else begin
          a_wr = 1'b1; a_stall = 0;
        end
        a_pwr = a_wr;
      end
    end
  end

  // slave B: zero-wait, data valid in the accept cycle
  initial begin
    forever begin
      @(negedge clk);
      b_rdata = $urandom;
      if (rst_n && b_read) begin
        b_rdata = b_addr ? b_ts : b_id;
        b_log.push_back(b_addr);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (a_done) a_dcnt++;
      if (b_done) b_dcnt++;
    end
  end

  task automatic pulse_a();
    @(negedge clk) a_start = 1'b1;
    @(negedge clk) a_start = 1'b0;
  endtask

  task automatic pulse_b();
    @(negedge clk) b_start = 1'b1;
    @(negedge clk) b_start = 1'b0;
  endtask

  task automatic wait_a(input int lim, output int n);
    n = 0;
    do begin @(negedge clk); n++; end
    while (!a_done && n < lim);
  endtask

  task automatic wait_b(input int lim, output int n);
    n = 0;
    do begin @(negedge clk); n++; end
    while (!b_done && n < lim);
  endtask

  function automatic logic [67:0] res_a();
    return {a_pass, a_idok, a_tsok, a_tmo, a_idv, a_tsv};
  endfunction

  function automatic logic [67:0] res_b();
    return {b_pass, b_idok, b_tsok, b_tmo, b_idv, b_tsv};
  endfunction

  task automatic test_reset();
    logic [71:0] v;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    v = {a_busy, a_done, a_idok, a_tsok, a_pass, a_tmo,
         a_read, a_addr, a_idv, a_tsv};
    total++;
    if (v !== '0) begin
      bad++; $display("FAIL reset_a got=%h want=0", v);
    end
    v = {b_busy, b_done, b_idok, b_tsok, b_pass, b_tmo,
         b_read, b_addr, b_idv, b_tsv};
    total++;
    if (v !== '0) begin
      bad++; $display("FAIL reset_b got=%h want=0", v);
    end
    qa.push_back({4'b1110, 32'h0, TS_GOOD});
    qb.push_back({4'b1110, 32'h0, TS_GOOD});
    a_log.delete(); b_log.delete();
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_auto_run();
    int n, cb, ca;
    logic [67:0] e;
    cb = b_dcnt; ca = a_dcnt;
    wait_b(40, n);
    total++;
    if (!b_done) begin
      bad++; $display("FAIL auto_b_done got=0 want=1");
    end
    e = qb.pop_front();
    total++;
    if (res_b() !== e) begin
      bad++; $display("FAIL auto_b_res got=%h want=%h", res_b(), e);
    end
    repeat (3) @(negedge clk);
    total++;
    if (b_dcnt - cb != 1) begin
      bad++; $display("FAIL auto_b_once got=%0d want=1", b_dcnt - cb);
    end
    total++;
    if (b_log.size() != 2 || b_log[0] !== 1'b0 || b_log[1] !== 1'b1) begin
      bad++; $display("FAIL auto_b_addr got=%p want=0,1", b_log);
    end
    wait_a(100, n);
    total++;
    if (!a_done) begin
      bad++; $display("FAIL auto_a_done got=0 want=1");
    end
    e = qa.pop_front();
    total++;
    if (res_a() !== e) begin
      bad++; $display("FAIL auto_a_res got=%h want=%h", res_a(), e);
    end
    repeat (3) @(negedge clk);
    total++;
    if (a_dcnt - ca != 1) begin
      bad++; $display("FAIL auto_a_once got=%0d want=1", a_dcnt - ca);
    end
    total++;
    if (a_log.size() != 2 || a_log[0] !== 1'b0 || a_log[1] !== 1'b1) begin
      bad++; $display("FAIL auto_a_addr got=%p want=0,1", a_log);
    end
  endtask

  task automatic test_id_mismatch();
    int n, cb;
    logic [67:0] e;
    b_id = 32'h0000_0001;
    cb = b_dcnt;
    qb.push_back({4'b0010, 32'h1, TS_GOOD});
    pulse_b();
    wait_b(40, n);
    total++;
    if (!b_done) begin
      bad++; $display("FAIL idmis_done got=0 want=1");
    end
    e = qb.pop_front();
    total++;
    if (res_b() !== e) begin
      bad++; $display("FAIL idmis_res got=%h want=%h", res_b(), e);
    end
    repeat (3) @(negedge clk);
    total++;
    if (b_dcnt - cb != 1) begin
      bad++; $display("FAIL idmis_once got=%0d want=1", b_dcnt - cb);
    end
  endtask

  task automatic test_ts_nocheck();
    int n;
    logic [67:0] e;
    b_id = 32'h0;
    b_ts = 32'hDEAD_BEEF;
    b_log.delete();
    qb.push_back({4'b1110, 32'h0, 32'hDEAD_BEEF});
    pulse_b();
    wait_b(40, n);
    e = qb.pop_front();
    total++;
    if (!b_done || res_b() !== e) begin
      bad++; $display("FAIL tsnochk_res done=%b got=%h want=%h",
                      b_done, res_b(), e);
    end
    total++;
    if (b_log.size() != 2 || b_log[0] !== 1'b0 || b_log[1] !== 1'b1) begin
      bad++; $display("FAIL tsnochk_addr got=%p want=0,1", b_log);
    end
  endtask

  task automatic test_ts_mismatch();
    int n;
    logic [67:0] e;
    a_ts = 32'h1234_5678;
    qa.push_back({4'b0100, 32'h0, 32'h1234_5678});
    pulse_a();
    wait_a(100, n);
    e = qa.pop_front();
    total++;
    if (!a_done || res_a() !== e) begin
      bad++; $display("FAIL tsmis_res done=%b got=%h want=%h",
                      a_done, res_a(), e);
    end
  endtask

  task automatic test_stall_rdv();
    int n;
    logic [67:0] e;
    a_ts = TS_GOOD; a_wait = 2; a_dly = 1;
    a_log.delete();
    qa.push_back({4'b1110, 32'h0, TS_GOOD});
    pulse_a();
    wait_a(100, n);
    e = qa.pop_front();
    total++;
    if (!a_done || res_a() !== e) begin
      bad++; $display("FAIL stall_res done=%b got=%h want=%h",
                      a_done, res_a(), e);
    end
    total++;
    if (a_log.size() != 2 || a_log[0] !== 1'b0 || a_log[1] !== 1'b1) begin
      bad++; $display("FAIL stall_addr got=%p want=0,1", a_log);
    end
    total++;
    if (a_stv != 0) begin
      bad++; $display("FAIL stall_stable got=%0d want=0", a_stv);
    end
    total++;
    if (a_ovl != 0) begin
      bad++; $display("FAIL stall_outstanding got=%0d want=0", a_ovl);
    end
  endtask

  task automatic test_timeout();
    int n, ca;
    logic [67:0] e;
    a_dead = 1'b1;
    a_att = 0;
    ca = a_dcnt;
    qa.push_back({4'b0001, 32'h0, TS_GOOD});
    pulse_a();
    wait_a(200, n);
    total++;
    if (!a_done) begin
      bad++; $display("FAIL tmo_done got=0 want=1");
    end
    e = qa.pop_front();
    total++;
    if (res_a() !== e) begin
      bad++; $display("FAIL tmo_res got=%h want=%h", res_a(), e);
    end
    total++;
    if (a_att != 3) begin
      bad++; $display("FAIL tmo_attempts got=%0d want=3", a_att);
    end
    total++;
    if (n < 47 || n > 53) begin
      bad++; $display("FAIL tmo_cycles got=%0d want=47..53", n);
    end
    repeat (3) @(negedge clk);
    total++;
    if (a_dcnt - ca != 1) begin
      bad++; $display("FAIL tmo_once got=%0d want=1", a_dcnt - ca);
    end
  endtask

  task automatic test_recover();
    int n;
    logic [67:0] e;
    a_dead = 1'b0; a_wait = 0; a_dly = 2;
    qa.push_back({4'b1110, 32'h0, TS_GOOD});
    pulse_a();
    wait_a(100, n);
    e = qa.pop_front();
    total++;
    if (!a_done || res_a() !== e) begin
      bad++; $display("FAIL recover_res done=%b got=%h want=%h",
                      a_done, res_a(), e);
    end
  endtask

  task automatic test_start_busy();
    int n, ca;
    logic [67:0] e;
    a_wait = 3; a_dly = 3; a_ts = 32'hCAFE_0001;
    ca = a_dcnt;
    qa.push_back({4'b0100, 32'h0, 32'hCAFE_0001});
    pulse_a();
    repeat (4) @(negedge clk);
    total++;
    if (a_busy !== 1'b1) begin
      bad++; $display("FAIL busy_flag got=%b want=1", a_busy);
    end
    pulse_a();
    wait_a(100, n);
    e = qa.pop_front();
    total++;
    if (!a_done || res_a() !== e) begin
      bad++; $display("FAIL busy_res done=%b got=%h want=%h",
                      a_done, res_a(), e);
    end
    repeat (30) @(negedge clk);
    total++;
    if (a_dcnt - ca != 1 || a_busy !== 1'b0) begin
      bad++; $display("FAIL busy_ignore dones=%0d busy=%b want=1,0",
                      a_dcnt - ca, a_busy);
    end
  endtask

  task automatic test_reset_mid();
    int n, k;
    logic [67:0] e;
    logic [71:0] v;
    a_ts = TS_GOOD; a_wait = 0; a_dly = 3;
    a_log.delete();
    pulse_a();
    k = 0;
    while (a_log.size() < 2 && k < 50) begin
      @(negedge clk); k++;
    end
    total++;
    if (a_log.size() < 2) begin
      bad++; $display("FAIL rstmid_reach got=%0d want=2", a_log.size());
    end
    repeat (2) @(negedge clk);
    total++;
    if (a_busy !== 1'b1 || a_read !== 1'b0) begin
      bad++; $display("FAIL rstmid_wt busy=%b read=%b want=1,0",
                      a_busy, a_read);
    end
    rst_n = 1'b0;
    #1;
    v = {a_busy, a_done, a_idok, a_tsok, a_pass, a_tmo,
         a_read, a_addr, a_idv, a_tsv};
    total++;
    if (v !== '0) begin
      bad++; $display("FAIL rstmid_clear got=%h want=0", v);
    end
    qa.push_back({4'b1110, 32'h0, TS_GOOD});
    qb.push_back({4'b1110, 32'h0, 32'hDEAD_BEEF});
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_b(40, n);
    e = qb.pop_front();
    total++;
    if (!b_done || res_b() !== e) begin
      bad++; $display("FAIL rstmid_b done=%b got=%h want=%h",
                      b_done, res_b(), e);
    end
    wait_a(100, n);
    e = qa.pop_front();
    total++;
    if (!a_done || res_a() !== e) begin
      bad++; $display("FAIL rstmid_a done=%b got=%h want=%h",
                      a_done, res_a(), e);
    end
  endtask

  initial begin
    test_reset();
    test_auto_run();
    test_id_mismatch();
    test_ts_nocheck();
    test_ts_mismatch();
    test_stall_rdv();
    test_timeout();
    test_recover();
    test_start_busy();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
